core_csr_access: RTL and testbench

Sequencer between instruction decode and the CSR register file. It executes Zicsr read-modify-write operations (CSRRW/CSRRS/CSRRC and their immediate forms) as a multi-cycle transaction: read old value, compute new value, issue one write strobe, return old value to writeback. Valid/ready handshakes on both sides; the CSR file's combinational read port is driven through CSR_ADDR/CSR_RDATA.

---
 rtl/core_csr_access.sv | 140 ++++++++++++++
 tb/tb_core_csr_access.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_csr_access.sv
// Zicsr read-modify-write sequencer between instruction decode and the CSR register file.
// Define CORE_CSR_RO_CHECK_EN to make writes to read-only CSR space (addr[11:10]==2'b11) illegal.
module core_csr_access (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [1:0]  REQ_OP,
    input  logic [11:0] REQ_ADDR,
    input  logic [31:0] REQ_SRC,
    input  logic        REQ_SRC_ZERO,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ILLEGAL,
    output logic [11:0] CSR_ADDR,
    output logic [31:0] CSR_WDATA,
    output logic        CSR_WE,
    input  logic [31:0] CSR_RDATA
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_RSVD = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    state_t      state;
    logic [1:0]  op_q;
    logic [11:0] addr_q;
    logic [31:0] src_q;
    logic        zero_q;
    logic [31:0] new_q;
    logic [31:0] rdata_q;
    logic        illegal_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        csr_we_q;

    logic [31:0] new_val;
    logic        wr;
    logic        ro_hit;
    logic        illegal;

    always_comb begin
        // NOTE: default assigned first so no op value leaves new_val unassigned (no latch).
        new_val = src_q;
        case (op_q)
            OP_RS:   new_val = CSR_RDATA | src_q;
            OP_RC:   new_val = CSR_RDATA & ~src_q;
            default: new_val = src_q;
        endcase
    end

    // RS/RC with a zero source are pure reads; RW always writes.
    assign wr = (op_q == OP_RW) || (((op_q == OP_RS) || (op_q == OP_RC)) && !zero_q);

`ifdef CORE_CSR_RO_CHECK_EN
    assign ro_hit = wr && (addr_q[11:10] == 2'b11);
`else
    assign ro_hit = 1'b0;
`endif

    assign illegal = (op_q == OP_RSVD) || ro_hit;

    // NOTE: every register here uses non-blocking assignment so all of them sample pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            src_q       <= '0;
            zero_q      <= 1'b0;
            new_q       <= '0;
            rdata_q     <= '0;
            illegal_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            csr_we_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        op_q        <= REQ_OP;
                        addr_q      <= REQ_ADDR;
                        src_q       <= REQ_SRC;
                        zero_q      <= REQ_SRC_ZERO;
                        req_ready_q <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    new_q     <= new_val;
                    rdata_q   <= illegal ? '0 : CSR_RDATA;
                    illegal_q <= illegal;
                    if (wr && !illegal) begin
                        csr_we_q <= 1'b1;
                        state    <= WRITE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                WRITE: begin
                    csr_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    csr_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign REQ_READY   = req_ready_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_RDATA   = rdata_q;
    assign RSP_ILLEGAL = illegal_q;
    assign CSR_ADDR    = addr_q;
    assign CSR_WDATA   = new_q;
    assign CSR_WE      = csr_we_q;

endmodule

// File: tb/tb_core_csr_access.sv
// Bench for core_csr_access: a CSR-file model drives CSR_RDATA, a transaction-level model predicts
// every cycle's outputs, and directed transactions pin literal values and latencies.
module tb_core_csr_access;

    logic        CLK;
    logic        RST_N;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [1:0]  REQ_OP;
    logic [11:0] REQ_ADDR;
    logic [31:0] REQ_SRC;
    logic        REQ_SRC_ZERO;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [31:0] RSP_RDATA;
    logic        RSP_ILLEGAL;
    logic [11:0] CSR_ADDR;
    logic [31:0] CSR_WDATA;
    logic        CSR_WE;
    logic [31:0] CSR_RDATA;

`ifdef CORE_CSR_RO_CHECK_EN
    localparam bit RO_CHECK = 1'b1;
`else
    localparam bit RO_CHECK = 1'b0;
`endif

    typedef struct packed {
        logic        do_wr;
        logic        ill;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } pred_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    core_csr_access dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .REQ_VALID    (REQ_VALID),
        .REQ_READY    (REQ_READY),
        .REQ_OP       (REQ_OP),
        .REQ_ADDR     (REQ_ADDR),
        .REQ_SRC      (REQ_SRC),
        .REQ_SRC_ZERO (REQ_SRC_ZERO),
        .RSP_VALID    (RSP_VALID),
        .RSP_READY    (RSP_READY),
        .RSP_RDATA    (RSP_RDATA),
        .RSP_ILLEGAL  (RSP_ILLEGAL),
        .CSR_ADDR     (CSR_ADDR),
        .CSR_WDATA    (CSR_WDATA),
        .CSR_WE       (CSR_WE),
        .CSR_RDATA    (CSR_RDATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // CSR file seen by the DUT; the read-only space ignores writes.
    logic [31:0] csr_file [4096] = '{default: '0};
    assign CSR_RDATA = csr_file[CSR_ADDR];
    always @(posedge CLK) begin
        if (CSR_WE && CSR_ADDR < 12'hC00) csr_file[CSR_ADDR] <= CSR_WDATA;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic pred_t predict(input logic [1:0] op, input logic [11:0] addr,
                                      input logic [31:0] src, input logic zero,
                                      input logic [31:0] old);
        pred_t p;
        logic  wants_write;
        logic  ill;
        wants_write = (op == 2'b01) || (op != 2'b00 && !zero);
        ill = (op == 2'b00) || (RO_CHECK && wants_write && addr >= 12'hC00);
        case (op)
            2'b01:   p.wdata = src;
            2'b10:   p.wdata = old | src;
            default: p.wdata = old & ~src;
        endcase
        p.ill   = ill;
        p.do_wr = wants_write && !ill;
        p.rdata = ill ? 32'h0 : old;
        return p;
    endfunction

    // Transaction model: shadow CSR contents plus the single in-flight request.
    logic [31:0] shadow [4096] = '{default: '0};
    logic        m_busy = 1'b0;
    int          m_acc = 0;
    logic [11:0] m_addr = '0;
    pred_t       m_pred = '0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_busy <= 1'b0;
            m_addr <= '0;
        end else if (!m_busy) begin
            if (REQ_VALID) begin
                m_busy <= 1'b1;
                m_acc  <= cyc;
                m_addr <= REQ_ADDR;
                m_pred <= predict(REQ_OP, REQ_ADDR, REQ_SRC, REQ_SRC_ZERO, shadow[REQ_ADDR]);
            end
        end else begin
            if (m_pred.do_wr && cyc == m_acc + 2 && m_addr < 12'hC00) shadow[m_addr] <= m_pred.wdata;
            if (cyc >= m_acc + (m_pred.do_wr ? 3 : 2) && RSP_READY) m_busy <= 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (RST_N) begin
            check("cmp.req_ready", {31'b0, REQ_READY}, {31'b0, !m_busy});
            check("cmp.csr_addr", {20'b0, CSR_ADDR}, {20'b0, m_addr});
            check("cmp.csr_we", {31'b0, CSR_WE},
                  {31'b0, m_busy && m_pred.do_wr && cyc == m_acc + 2});
            check("cmp.rsp_valid", {31'b0, RSP_VALID},
                  {31'b0, m_busy && cyc >= m_acc + (m_pred.do_wr ? 3 : 2)});
            if (m_busy && m_pred.do_wr && cyc == m_acc + 2)
                check("cmp.csr_wdata", CSR_WDATA, m_pred.wdata);
            if (m_busy && cyc >= m_acc + (m_pred.do_wr ? 3 : 2)) begin
                check("cmp.rsp_rdata", RSP_RDATA, m_pred.rdata);
                check("cmp.rsp_illegal", {31'b0, RSP_ILLEGAL}, {31'b0, m_pred.ill});
            end
        end
    end

    task automatic do_txn(input string name, input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] src, input logic zero, input int hold,
                          input bit exp_we, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rdata, input logic exp_ill);
        int          we_n;
        int          we_cyc;
        int          rsp_cyc;
        logic [31:0] wd;
        we_n = 0;
        we_cyc = -1;
        rsp_cyc = -1;
        wd = '0;
        @(negedge CLK);
        check({name, ".req_ready"}, {31'b0, REQ_READY}, 32'd1);
        REQ_VALID = 1'b1;
        REQ_OP = op;
        REQ_ADDR = addr;
        REQ_SRC = src;
        REQ_SRC_ZERO = zero;
        @(posedge CLK);
        for (int t = 1; t <= 16 && rsp_cyc < 0; t++) begin
            @(negedge CLK);
            REQ_VALID = 1'b0;
            if (CSR_WE) begin
                we_n++;
                we_cyc = t;
                wd = CSR_WDATA;
            end
            if (RSP_VALID) rsp_cyc = t;
        end
        check({name, ".rsp_cycle"}, rsp_cyc, exp_we ? 32'd3 : 32'd2);
        check({name, ".rsp_rdata"}, RSP_RDATA, exp_rdata);
        check({name, ".rsp_illegal"}, {31'b0, RSP_ILLEGAL}, {31'b0, exp_ill});
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            if (CSR_WE) we_n++;
            check({name, ".hold_valid"}, {31'b0, RSP_VALID}, 32'd1);
            check({name, ".hold_rdata"}, RSP_RDATA, exp_rdata);
            check({name, ".hold_ready"}, {31'b0, REQ_READY}, 32'd0);
        end
        check({name, ".we_count"}, we_n, exp_we ? 32'd1 : 32'd0);
        if (exp_we) begin
            check({name, ".we_cycle"}, we_cyc, 32'd2);
            check({name, ".wdata"}, wd, exp_wdata);
        end
        RSP_READY = 1'b1;
        @(negedge CLK);
        RSP_READY = 1'b0;
        check({name, ".done_valid"}, {31'b0, RSP_VALID}, 32'd0);
        check({name, ".done_ready"}, {31'b0, REQ_READY}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        RST_N = 1'b0;
        RSP_READY = 1'b0;
        // A request presented during reset must be ignored.
        REQ_VALID = 1'b1;
        REQ_OP = 2'b01;
        REQ_ADDR = 12'h123;
        REQ_SRC = 32'h0000_00FF;
        REQ_SRC_ZERO = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst.req_ready", {31'b0, REQ_READY}, 32'd1);
        check("rst.csr_we", {31'b0, CSR_WE}, 32'd0);
        check("rst.rsp_valid", {31'b0, RSP_VALID}, 32'd0);
        check("rst.rsp_rdata", RSP_RDATA, 32'd0);
        check("rst.rsp_illegal", {31'b0, RSP_ILLEGAL}, 32'd0);
        check("rst.csr_addr", {20'b0, CSR_ADDR}, 32'd0);
        check("rst.csr_wdata", CSR_WDATA, 32'd0);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("post_rst.req_ready", {31'b0, REQ_READY}, 32'd1);
        check("post_rst.csr_addr", {20'b0, CSR_ADDR}, 32'd0);

        do_txn("rw_305", 2'b01, 12'h305, 32'h8000_0100, 1'b0, 0, 1'b1, 32'h8000_0100, 32'h0, 1'b0);
        do_txn("rs_305_zero", 2'b10, 12'h305, 32'h0, 1'b1, 0, 1'b0, 32'h0, 32'h8000_0100, 1'b0);
        do_txn("rs_300", 2'b10, 12'h300, 32'h8, 1'b0, 0, 1'b1, 32'h0000_0008, 32'h0, 1'b0);
        do_txn("rc_300", 2'b11, 12'h300, 32'h8, 1'b0, 0, 1'b1, 32'h0000_0000, 32'h0000_0008, 1'b0);
        do_txn("rw_300_zero", 2'b01, 12'h300, 32'h0, 1'b1, 0, 1'b1, 32'h0, 32'h0, 1'b0);
        if (RO_CHECK)
            do_txn("rw_f14", 2'b01, 12'hF14, 32'h0000_1234, 1'b0, 0, 1'b0, 32'h0, 32'h0, 1'b1);
        else
            do_txn("rw_f14", 2'b01, 12'hF14, 32'h0000_1234, 1'b0, 0, 1'b1, 32'h0000_1234, 32'h0, 1'b0);
        do_txn("rs_f11_zero", 2'b10, 12'hF11, 32'h0, 1'b1, 0, 1'b0, 32'h0, 32'h0, 1'b0);
        do_txn("op_00", 2'b00, 12'h305, 32'h0000_FFFF, 1'b0, 0, 1'b0, 32'h0, 32'h0, 1'b1);
        do_txn("rs_305_bp", 2'b10, 12'h305, 32'h3, 1'b0, 5, 1'b1, 32'h8000_0103, 32'h8000_0100, 1'b0);
        do_txn("rc_305", 2'b11, 12'h305, 32'h8000_0000, 1'b0, 0, 1'b1, 32'h0000_0103, 32'h8000_0103, 1'b0);

        // Reset asserted in the middle of the WRITE cycle, before its strobe edge.
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_OP = 2'b01;
        REQ_ADDR = 12'h341;
        REQ_SRC = 32'hDEAD_BEEF;
        REQ_SRC_ZERO = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        check("rst_mid.we_before", {31'b0, CSR_WE}, 32'd1);
        #2 RST_N = 1'b0;
        #1;
        check("rst_mid.we_dropped", {31'b0, CSR_WE}, 32'd0);
        check("rst_mid.req_ready", {31'b0, REQ_READY}, 32'd1);
        @(negedge CLK);
        RST_N = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge CLK);
            if (RSP_VALID) seen++;
        end
        check("rst_mid.no_rsp", seen, 32'd0);
        check("rst_mid.csr_kept", csr_file[12'h341], 32'h0);

        do_txn("rs_341_after", 2'b10, 12'h341, 32'h1, 1'b0, 0, 1'b1, 32'h0000_0001, 32'h0, 1'b0);

        repeat (2) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
